serial_slice_adder_ctrl: RTL and testbench



---
 rtl/adder_pkg.sv | 23 ++
 rtl/slice_ripple_adder.sv | 46 ++++
 rtl/serial_slice_adder_ctrl.sv | 116 +++++++++++
 tb/tb_serial_slice_adder_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the serial slice adder: controller states and
// sizing helpers used to derive the slice count and slice index width.
package adder_pkg;

    // Controller states: waiting for operands, adding slices, holding a result
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of slice passes needed to cover a full operand
    function automatic int calc_nslices(input int width, input int slice);
        return width / slice;
    endfunction

    // Width of the slice index; never narrower than one bit so a
    // single-slice configuration still has a legal port
    function automatic int calc_idx_width(input int nslices);
        return (nslices > 1) ? $clog2(nslices) : 1;
    endfunction

endpackage

// File: rtl/slice_ripple_adder.sv
// Narrow combinational ripple-carry adder built from one-bit full adder
// cells. The sequencer reuses a single instance for every slice of a wide add.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Classic one-bit full adder: sum is the parity, carry is the majority
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

module slice_ripple_adder #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[SLICE];

    // Chain of full adders, carry rippling from bit 0 toward the MSB
    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/serial_slice_adder_ctrl.sv
// Multi-cycle wide adder. Operands are captured through a valid/ready
// handshake, added one narrow slice per clock (LSB slice first) through a
// single shared ripple adder, and the result is presented through a second
// valid/ready handshake.

module serial_slice_adder_ctrl
    import adder_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int SLICE   = 4,
    localparam int NSLICES = calc_nslices(WIDTH, SLICE),
    localparam int IDXW    = calc_idx_width(NSLICES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [IDXW-1:0]  slice_idx
);

    // Refuse to elaborate a geometry the slice sequencer cannot cover exactly
    if (((WIDTH % SLICE) != 0) || (SLICE < 2)) begin : g_bad_params
        $error("serial_slice_adder_ctrl: WIDTH must be a multiple of SLICE and SLICE must be at least 2");
    end

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             accept;
    logic             release_result;

    // Handshake flags and status are pure decodes of the registered state
    always_comb begin
        in_ready       = (state == ST_IDLE);
        out_valid      = (state == ST_DONE);
        busy           = (state == ST_RUN) || (state == ST_DONE);
        accept         = in_valid && (state == ST_IDLE);
        release_result = out_ready && (state == ST_DONE);
    end

    // Steer the current slice of the captured operands into the shared adder
    always_comb begin
        slice_a = op_a[int'(slice_idx)*SLICE +: SLICE];
        slice_b = op_b[int'(slice_idx)*SLICE +: SLICE];
    end

    slice_ripple_adder #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Sequencer: capture on accept, one slice per edge in RUN, hold in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            slice_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_a      <= a;
                        op_b      <= b;
                        carry     <= cin;
                        slice_idx <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[int'(slice_idx)*SLICE +: SLICE] <= slice_sum;
                    carry <= slice_cout;
                    if (slice_idx == LAST_IDX) begin
                        cout      <= slice_cout;
                        slice_idx <= '0;
                        state     <= ST_DONE;
                    end else begin
                        slice_idx <= slice_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (release_result) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_slice_adder_ctrl.sv
// Self-checking bench for serial_slice_adder_ctrl (WIDTH=16, SLICE=4).
// Expected results are pushed to a scoreboard queue when a request is
// driven and popped when the adder presents its result.

module tb_serial_slice_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
    logic [1:0]  slice_idx;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [16:0] exp_q[$];

    serial_slice_adder_ctrl #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .slice_idx (slice_idx)
    );

    always #5 clk = ~clk;

    // Drive a request, record its expected result, and wait for acceptance
    task automatic send_request(input logic [15:0] ta, input logic [15:0] tb_v,
                                input logic tcin, output logic timed_out);
        a        = ta;
        b        = tb_v;
        cin      = tcin;
        in_valid = 1'b1;
        exp_q.push_back({1'b0, ta} + {1'b0, tb_v} + {16'd0, tcin});
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, counting edges since the call
    task automatic wait_result(output logic timed_out, output int cycles);
        timed_out = 1'b1;
        cycles    = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (out_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'hA5A5;
        b         = 16'h5A5A;
        cin       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (sum !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_sum: got %h expected 0000", sum); end
        tests_run++; if (cout !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
        tests_run++; if (slice_idx !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_slice_idx: got %0d expected 0", slice_idx); end
    endtask

    task automatic test_basic();
        logic        to;
        int          cyc;
        logic [16:0] exp;
        out_ready = 1'b1;
        send_request(16'h1234, 16'h4321, 1'b0, to);
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_accept_timeout: got %b expected 0", to); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_busy_run: got %b expected 1", busy); end
        wait_result(to, cyc);
        tests_run++; if (cyc !== 4) begin tests_failed++; $display("[TB] FAIL basic_latency: got %0d expected 4", cyc); end
        exp = exp_q.pop_front();
        tests_run++; if (sum !== exp[15:0]) begin tests_failed++; $display("[TB] FAIL basic_sum: got %h expected %h", sum, exp[15:0]); end
        tests_run++; if (cout !== exp[16]) begin tests_failed++; $display("[TB] FAIL basic_cout: got %b expected %b", cout, exp[16]); end
        @(posedge clk);
        #1;
        tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_return_idle: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_carry();
        logic        to;
        int          cyc;
        logic [16:0] exp;
        out_ready = 1'b1;
        send_request(16'hFFFF, 16'h0000, 1'b1, to);
        wait_result(to, cyc);
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("[TB] FAIL carry_cin_timeout: got %b expected 0", to); end
        exp = exp_q.pop_front();
        tests_run++; if ({cout, sum} !== exp) begin tests_failed++; $display("[TB] FAIL carry_cin_result: got %h expected %h", {cout, sum}, exp); end
        @(posedge clk);
        #1;
        send_request(16'hFFFF, 16'h0001, 1'b0, to);
        wait_result(to, cyc);
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("[TB] FAIL carry_b_timeout: got %b expected 0", to); end
        exp = exp_q.pop_front();
        tests_run++; if ({cout, sum} !== exp) begin tests_failed++; $display("[TB] FAIL carry_b_result: got %h expected %h", {cout, sum}, exp); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic        to;
        int          cyc;
        logic [16:0] exp;
        int          unstable;
        out_ready = 1'b0;
        send_request(16'h8000, 16'h8000, 1'b0, to);
        wait_result(to, cyc);
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_timeout: got %b expected 0", to); end
        exp = exp_q.pop_front();
        a        = 16'h0003;
        b        = 16'h0004;
        cin      = 1'b0;
        in_valid = 1'b1;
        exp_q.push_back(17'h00007);
        unstable = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp) unstable++;
            @(posedge clk);
            #1;
        end
        tests_run++; if (unstable !== 0) begin tests_failed++; $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", unstable); end
        tests_run++; if ({cout, sum} !== exp) begin tests_failed++; $display("[TB] FAIL bp_result: got %h expected %h", {cout, sum}, exp); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_idle_before_accept: got busy=%b in_ready=%b expected 0/1", busy, in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_pending_accept: got busy=%b expected 1", busy); end
        wait_result(to, cyc);
        exp = exp_q.pop_front();
        tests_run++; if (to !== 1'b0 || {cout, sum} !== exp) begin tests_failed++; $display("[TB] FAIL bp_pending_result: got %h timeout=%b expected %h", {cout, sum}, to, exp); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_operand_change();
        logic        to;
        int          cyc;
        logic [16:0] exp;
        out_ready = 1'b1;
        send_request(16'h00F0, 16'h0010, 1'b0, to);
        a   = 16'hFFFF;
        b   = 16'hFFFF;
        cin = 1'b1;
        wait_result(to, cyc);
        exp = exp_q.pop_front();
        tests_run++; if (to !== 1'b0 || sum !== exp[15:0]) begin tests_failed++; $display("[TB] FAIL opchg_sum: got %h timeout=%b expected %h", sum, to, exp[15:0]); end
        tests_run++; if (cout !== exp[16]) begin tests_failed++; $display("[TB] FAIL opchg_cout: got %b expected %b", cout, exp[16]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        logic        to;
        int          cyc;
        int          pulses;
        logic [16:0] exp;
        out_ready = 1'b1;
        send_request(16'h7777, 16'h1111, 1'b1, to);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++; if (busy !== 1'b0 || in_ready !== 1'b1 || slice_idx !== 2'd0) begin tests_failed++; $display("[TB] FAIL midrst_idle: got busy=%b in_ready=%b idx=%0d expected 0/1/0", busy, in_ready, slice_idx); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) pulses++;
            @(posedge clk);
            #1;
        end
        tests_run++; if (pulses !== 0) begin tests_failed++; $display("[TB] FAIL midrst_no_output: got %0d out_valid cycles expected 0", pulses); end
        send_request(16'h0001, 16'h0002, 1'b0, to);
        wait_result(to, cyc);
        exp = exp_q.pop_front();
        tests_run++; if (to !== 1'b0 || {cout, sum} !== exp) begin tests_failed++; $display("[TB] FAIL midrst_next_result: got %h timeout=%b expected %h", {cout, sum}, to, exp); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic        to;
        int          cyc;
        logic [16:0] exp;
        int          errs;
        out_ready = 1'b1;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            send_request(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), to);
            if (to) errs++;
            wait_result(to, cyc);
            exp = exp_q.pop_front();
            if (to || cyc != 4 || {cout, sum} !== exp) begin
                errs++;
                $display("[TB] FAIL b2b_item%0d: got %h after %0d cycles expected %h after 4", i, {cout, sum}, cyc, exp);
            end
        end
        tests_run++; if (errs !== 0) begin tests_failed++; $display("[TB] FAIL b2b_total: got %0d bad transactions expected 0", errs); end
        tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_operand_change();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
